// File: rtl/uinst_pkg.sv
// Shared constants and types for the decode->execute microinstruction register.
//   UINST_W / PC_W / CNT_W : default widths of the word, micro-PC tag and squash counter
//   NOP_UINST              : word substituted for a squashed microinstruction
//   uinst_entry_t          : one held entry {uinst, upc, squashed} at default widths
//   occ_e                  : skid-buffer occupancy state
package uinst_pkg;

  localparam int unsigned UINST_W = 24;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned CNT_W   = 8;

  localparam logic [UINST_W-1:0] NOP_UINST = '0;

  typedef struct packed {
    logic [UINST_W-1:0] uinst;
    logic [PC_W-1:0]    upc;
    logic               squashed;
  } uinst_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/uinst_skid_buf.sv
// Two-entry FIFO (head + skid) with valid/ready on both sides and a flush.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : empty the buffer; a same-edge write is dropped
//   i_wr_valid/o_wr_ready/i_wr_data : write side
//   o_rd_valid/i_rd_ready/o_rd_data : read side, head entry drives o_rd_data
module uinst_skid_buf
  import uinst_pkg::*;
#(
  parameter int unsigned       DATA_W   = 1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data
);

  occ_e              r_occ;
  occ_e              w_occ_nxt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic              w_wr;
  logic              w_rd;
  logic              w_head_ld_in;
  logic              w_head_ld_skid;
  logic              w_skid_ld;

  // Ready depends only on registered occupancy, never on i_wr_valid.
  assign o_wr_ready = ~rst & (r_occ != OCC_FULL);
  assign o_rd_valid = (r_occ != OCC_EMPTY);
  assign o_rd_data  = r_head;
  assign w_wr       = i_wr_valid & o_wr_ready;
  assign w_rd       = o_rd_valid & i_rd_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) r_occ <= OCC_EMPTY;
    else     r_occ <= w_occ_nxt;
  end

  // Next occupancy and data-register load enables.
  always_comb begin
    w_occ_nxt      = r_occ;
    w_head_ld_in   = 1'b0;
    w_head_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      unique case (r_occ)
        OCC_EMPTY: begin
          if (w_wr) begin
            w_head_ld_in = 1'b1;
            w_occ_nxt    = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_wr && w_rd) begin
            w_head_ld_in = 1'b1;
          end else if (w_wr) begin
            w_skid_ld = 1'b1;
            w_occ_nxt = OCC_FULL;
          end else if (w_rd) begin
            w_occ_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // Writes are blocked when full; a read promotes the skid entry.
          if (w_rd) begin
            w_head_ld_skid = 1'b1;
            w_occ_nxt      = OCC_ONE;
          end
        end
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Head and skid data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= RST_DATA;
      r_skid <= RST_DATA;
    end else begin
      if (w_head_ld_in)        r_head <= i_wr_data;
      else if (w_head_ld_skid) r_head <= r_skid;
      if (w_skid_ld)           r_skid <= i_wr_data;
    end
  end

endmodule

// File: rtl/uinst_squash_reg.sv
// Decode->execute microinstruction pipeline register with squash substitution.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_uinst/in_upc : word from the microinstruction ROM
//   is_void                        : replace the word accepted at this edge with NOP_UINST
//   flush                          : discard all held words and any same-edge accept
//   out_valid/out_ready/out_uinst/out_upc/out_squashed : head word toward execute
//   squash_cnt                     : saturating count of squashed accepts since reset
module uinst_squash_reg
  import uinst_pkg::*;
#(
  parameter int unsigned        UINST_W   = uinst_pkg::UINST_W,
  parameter int unsigned        PC_W      = uinst_pkg::PC_W,
  parameter logic [UINST_W-1:0] NOP_UINST = uinst_pkg::NOP_UINST,
  parameter int unsigned        CNT_W     = uinst_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [UINST_W-1:0] in_uinst,
  input  logic [PC_W-1:0]    in_upc,
  input  logic               is_void,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [UINST_W-1:0] out_uinst,
  output logic [PC_W-1:0]    out_upc,
  output logic               out_squashed,
  output logic [CNT_W-1:0]   squash_cnt
);

  typedef struct packed {
    logic [UINST_W-1:0] uinst;
    logic [PC_W-1:0]    upc;
    logic               squashed;
  } entry_t;

  localparam int unsigned    ENTRY_W = $bits(entry_t);
  localparam entry_t         RST_ENTRY = '{uinst: NOP_UINST, upc: '0, squashed: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           w_wr_entry;
  entry_t           w_rd_entry;
  logic             w_acc;
  logic [CNT_W-1:0] r_cnt;

  // Squash substitution on the write side; the tag always passes through.
  always_comb begin
    w_wr_entry.uinst    = is_void ? NOP_UINST : in_uinst;
    w_wr_entry.upc      = in_upc;
    w_wr_entry.squashed = is_void;
  end

  uinst_skid_buf #(
    .DATA_W   (ENTRY_W),
    .RST_DATA (RST_ENTRY)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .i_wr_valid (in_valid),
    .o_wr_ready (in_ready),
    .i_wr_data  (w_wr_entry),
    .o_rd_valid (out_valid),
    .i_rd_ready (out_ready),
    .o_rd_data  (w_rd_entry)
  );

  assign out_uinst    = w_rd_entry.uinst;
  assign out_upc      = w_rd_entry.upc;
  assign out_squashed = w_rd_entry.squashed;

  // A flushed accept never reaches the buffer, so it is not counted either.
  assign w_acc = in_valid & in_ready & ~flush;

  // Saturating squash counter; survives flush.
  always_ff @(posedge clk) begin
    if (rst)                                      r_cnt <= '0;
    else if (w_acc && is_void && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign squash_cnt = r_cnt;

endmodule

// File: tb/tb_uinst_squash_reg.sv
module tb_uinst_squash_reg;
  import uinst_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_uinst = '0;
  logic [7:0]  in_upc = '0;
  logic        is_void = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_squashed;
  logic [23:0] out_uinst;
  logic [7:0]  out_upc, squash_cnt;

  logic        s_in_ready, s_out_valid, s_out_squashed;
  logic [23:0] s_out_uinst;
  logic [7:0]  s_out_upc;
  logic [1:0]  s_squash_cnt;

  int total = 0;
  int bad = 0;
  uinst_entry_t q[$];
  int m_cnt = 0;

  always #5 clk = ~clk;

  uinst_squash_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_uinst(in_uinst), .in_upc(in_upc), .is_void(is_void), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_uinst(out_uinst),
    .out_upc(out_upc), .out_squashed(out_squashed), .squash_cnt(squash_cnt)
  );

  uinst_squash_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_uinst(in_uinst), .in_upc(in_upc), .is_void(is_void), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_uinst(s_out_uinst),
    .out_upc(s_out_upc), .out_squashed(s_out_squashed), .squash_cnt(s_squash_cnt)
  );

  typedef struct {
    logic       v;
    logic [7:0] upc;
    logic       vd;
    logic       ordy;
    logic       exp_ready;
    logic       exp_valid;
  } vec_t;

  function automatic logic [23:0] mk(input logic [7:0] upc);
    mk = {8'hC3, upc, ~upc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] upc, input logic vd,
                     input logic ordy, input logic fl);
    in_valid  = v;
    in_upc    = upc;
    in_uinst  = mk(upc);
    is_void   = vd;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Compare outputs against the queue model, then advance one clock and update the model.
  task automatic step();
    logic exp_ready;
    logic acc, con;
    uinst_entry_t e;
    int sat;
    #1;
    exp_ready = !rst && (q.size() < 2);
    sat = (m_cnt > 3) ? 3 : m_cnt;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_uinst", 32'(out_uinst), 32'(q[0].uinst));
      chk("out_upc", 32'(out_upc), 32'(q[0].upc));
      chk("out_squashed", 32'(out_squashed), 32'(q[0].squashed));
    end
    chk("squash_cnt", 32'(squash_cnt), 32'(m_cnt));
    chk("sat_cnt", 32'(s_squash_cnt), 32'(sat));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      acc = in_valid && exp_ready;
      con = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) begin
          e.uinst    = is_void ? 24'h0 : in_uinst;
          e.upc      = in_upc;
          e.squashed = is_void;
          q.push_back(e);
          if (is_void && m_cnt < 255) m_cnt++;
        end
      end
    end
    #1;
  endtask

  vec_t bp[8];

  initial begin
    bp[0] = '{1'b1, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0};
    bp[1] = '{1'b1, 8'd21, 1'b0, 1'b0, 1'b1, 1'b1};
    bp[2] = '{1'b1, 8'd22, 1'b0, 1'b0, 1'b0, 1'b1};
    bp[3] = '{1'b1, 8'd22, 1'b0, 1'b0, 1'b0, 1'b1};
    bp[4] = '{1'b1, 8'd22, 1'b0, 1'b1, 1'b0, 1'b1};
    bp[5] = '{1'b1, 8'd22, 1'b0, 1'b1, 1'b1, 1'b1};
    bp[6] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b1};
    bp[7] = '{1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0};

    // Reset: two clocks with rst high, first edge unchecked.
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_uinst", 32'(out_uinst), 32'(NOP_UINST));
    chk("rst_out_upc", 32'(out_upc), 32'h0);
    chk("rst_out_squashed", 32'(out_squashed), 32'h0);
    step();

    // Back-to-back stream 0..9.
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      step();
    end
    drv(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    // Squash on upc 3 and 4.
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 8'(i), (i == 3 || i == 4), 1'b1, 1'b0);
      step();
    end
    drv(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("cnt_after_squash", 32'(squash_cnt), 32'd2);

    // is_void without an accept has no effect.
    drv(1'b0, 8'd9, 1'b1, 1'b1, 1'b0);
    step();
    step();

    // Backpressure table.
    for (int i = 0; i < 8; i++) begin
      drv(bp[i].v, bp[i].upc, bp[i].vd, bp[i].ordy, 1'b0);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(bp[i].exp_ready));
      chk("bp_out_valid", 32'(out_valid), 32'(bp[i].exp_valid));
      step();
    end

    // Flush at occupancy 2 with in_valid high.
    drv(1'b1, 8'd40, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 8'd41, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 8'd42, 1'b1, 1'b0, 1'b1); step();
    drv(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_cnt", 32'(squash_cnt), 32'd2);
    step();

    // Flush at occupancy 1 with a squashed word offered: dropped, not counted.
    drv(1'b1, 8'd50, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 8'd51, 1'b1, 1'b1, 1'b1); step();
    drv(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("flush_drop_cnt", 32'(squash_cnt), 32'd2);

    // Saturation: five squashed words.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'(60 + i), 1'b1, 1'b1, 1'b0);
      step();
    end
    drv(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("sat_final", 32'(s_squash_cnt), 32'd3);
    chk("cnt_final", 32'(squash_cnt), 32'd7);

    // Mid-stream reset with two held words.
    drv(1'b1, 8'd70, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 8'd71, 1'b0, 1'b0, 1'b0); step();
    drv(1'b1, 8'd72, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("mid_rst_uinst", 32'(out_uinst), 32'(NOP_UINST));
    chk("mid_rst_upc", 32'(out_upc), 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
